// File: rtl/bias_stream_ctrl.sv
// Bias ROM sequencer: sweeps ROM entries 0..MEM_SIZE-1 REPEAT times per
// ap_start and streams every word into the output FIFO through a 2-entry
// buffer that absorbs the 1-cycle ROM latency and FIFO backpressure.
module bias_stream_ctrl #(
  parameter int unsigned MEM_SIZE   = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned REPEAT     = 1
) (
  input  logic                                        ap_clk,
  input  logic                                        ap_rst_n,
  input  logic                                        ap_start,
  output logic                                        ap_idle,
  output logic                                        ap_done,
  output logic [((MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1)-1:0] bias_address,
  output logic                                        bias_ce,
  input  logic [DATA_WIDTH-1:0]                       bias_q,
  output logic [DATA_WIDTH-1:0]                       output_V_din,
  input  logic                                        output_V_full_n,
  output logic                                        output_V_write
);

  localparam int unsigned AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int unsigned RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(MEM_SIZE - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [RW-1:0]         rep_q, rep_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];
  logic [DATA_WIDTH-1:0] din_q, din_d;

  logic                  buf_vld_c;
  logic                  wr_c;
  logic                  ce_c;
  logic                  pop_c;
  logic                  push_c;
  logic [2:0]            occ_c;
  logic [DATA_WIDTH-1:0] head_c;

  // Buffer, write and issue logic; a word landing on bias_q is already the
  // head when the buffer is empty, so it can be written the cycle it arrives.
  always_comb begin
    buf_vld_c  = (cnt_q != 2'd0);
    wr_c       = (buf_vld_c | inflight_q) & output_V_full_n;
    head_c     = buf_vld_c ? buf_q[0] : bias_q;
    occ_c      = 3'(cnt_q) + 3'(inflight_q) - 3'(wr_c);
    ce_c       = (state_q == S_RUN) && (occ_c < 3'd2);
    pop_c      = wr_c & buf_vld_c;
    push_c     = inflight_q & ~(wr_c & ~buf_vld_c);
    buf_d      = buf_q;
    if (pop_c) begin
      buf_d[0] = buf_q[1];
    end
    if (push_c) begin
      buf_d[1'(cnt_q - 2'(pop_c))] = bias_q;
    end
    cnt_d      = cnt_q + 2'(push_c) - 2'(pop_c);
    inflight_d = ce_c;
    din_d      = wr_c ? head_c : din_q;
  end

  // Next-state and sweep counters.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rep_d   = rep_q;
    if (ce_c) begin
      if (addr_q == ADDR_LAST) begin
        addr_d = '0;
        rep_d  = rep_q + RW'(1);
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d = S_RUN;
          addr_d  = '0;
          rep_d   = '0;
        end
      end
      S_RUN: begin
        if (ce_c && (addr_q == ADDR_LAST) && (rep_q == REP_LAST)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((cnt_d == 2'd0) && !inflight_d) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rep_q      <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      buf_q      <= '{default: '0};
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rep_q      <= rep_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      buf_q      <= buf_d;
      din_q      <= din_d;
    end
  end

  assign ap_idle        = (state_q == S_IDLE);
  assign ap_done        = (state_q == S_DONE);
  assign bias_address   = addr_q;
  assign bias_ce        = ce_c;
  assign output_V_write = wr_c;
  assign output_V_din   = din_d;

endmodule
